lc3_pipe_ctrl: RTL and testbench

Pipeline controller for the LC-3 core. It generates the per-stage enables for fetch, decode, execute, writeback and PC update, including the `enable_decode` strobe that accompanies `npc_in`/`psr`/`instr_dout` into decode. It also squashes wrong-path instructions on taken branches and jumps, and sequences data-memory accesses through a small memory-state FSM, stalling the pipeline while an access is in flight.

---
 rtl/lc3_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: per-stage enables, branch squash and the data-memory access FSM.
// Enables are combinational from registered state plus the stall inputs; writeback is registered.
module lc3_pipe_ctrl #(
  parameter int unsigned RESET_FILL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  localparam int unsigned FillW = $clog2(RESET_FILL + 2);

  typedef enum logic [1:0] {
    StRead  = 2'd0,
    StInd   = 2'd1,
    StWrite = 2'd2,
    StIdle  = 2'd3
  } mem_state_e;

  mem_state_e       mem_q, mem_d;
  logic             ind_store_q, ind_store_d;
  logic             v_dec_q, v_dec_d;
  logic             v_exe_q, v_exe_d;
  logic             wb_q, wb_d;
  logic [FillW-1:0] fill_cnt_q, fill_cnt_d;

  logic [3:0] opcode;
  logic       fill_done;
  logic       stall;
  logic       alu_op;
  logic       unused_ir;

  assign opcode    = ir_exec[15:12];
  assign unused_ir = ^ir_exec[8:0];
  assign alu_op    = opcode inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};

  always_comb begin
    fill_done        = (fill_cnt_q == FillW'(RESET_FILL));
    stall            = (mem_q != StIdle) | ~complete_instr;
    enable_fetch     = fill_done & ~stall;
    enable_decode    = v_dec_q & ~stall;
    enable_execute   = v_exe_q & ~stall;
    br_taken         = enable_execute &
                       (((opcode == 4'b0000) & (|(ir_exec[11:9] & psr))) |
                        (opcode == 4'b1100));
    enable_updatePC  = enable_fetch | br_taken;
    enable_writeback = wb_q;
    mem_state        = mem_q;
  end

  always_comb begin
    fill_cnt_d  = fill_done ? fill_cnt_q : fill_cnt_q + FillW'(1);
    v_dec_d     = v_dec_q;
    v_exe_d     = v_exe_q;
    mem_d       = mem_q;
    ind_store_d = ind_store_q;

    // A taken branch kills the two younger instructions already in flight.
    if (!stall) begin
      if (br_taken) begin
        v_dec_d = 1'b0;
        v_exe_d = 1'b0;
      end else begin
        v_dec_d = enable_fetch;
        v_exe_d = v_dec_q;
      end
    end

    unique case (mem_q)
      StIdle: begin
        if (enable_execute) begin
          case (opcode)
            4'b0010, 4'b0110: mem_d = StRead;
            4'b0011, 4'b0111: mem_d = StWrite;
            4'b1010: begin
              mem_d       = StInd;
              ind_store_d = 1'b0;
            end
            4'b1011: begin
              mem_d       = StInd;
              ind_store_d = 1'b1;
            end
            default: mem_d = StIdle;
          endcase
        end
      end
      StInd: begin
        if (complete_data) mem_d = ind_store_q ? StWrite : StRead;
      end
      StRead, StWrite: begin
        if (complete_data) mem_d = StIdle;
      end
      default: mem_d = StIdle;
    endcase

    wb_d = (enable_execute & alu_op) | ((mem_q == StRead) & complete_data);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q       <= StIdle;
      ind_store_q <= 1'b0;
      v_dec_q     <= 1'b0;
      v_exe_q     <= 1'b0;
      wb_q        <= 1'b0;
      fill_cnt_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      ind_store_q <= ind_store_d;
      v_dec_q     <= v_dec_d;
      v_exe_q     <= v_exe_d;
      wb_q        <= wb_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Bench for lc3_pipe_ctrl: instruction-token/access-phase model checked every cycle,
// plus directed literal checks of the reset, ALU, branch, memory and stall scenarios.
module tb_lc3_pipe_ctrl;

  localparam int unsigned RESET_FILL = 1;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir_exec;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_updatePC;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_pipe_ctrl #(.RESET_FILL(RESET_FILL)) dut (
    .clock           (clock),
    .reset           (reset),
    .complete_instr  (complete_instr),
    .complete_data   (complete_data),
    .ir_exec         (ir_exec),
    .psr             (psr),
    .enable_fetch    (enable_fetch),
    .enable_updatePC (enable_updatePC),
    .enable_decode   (enable_decode),
    .enable_execute  (enable_execute),
    .enable_writeback(enable_writeback),
    .br_taken        (br_taken),
    .mem_state       (mem_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions are tagged tokens in decode/execute slots; a memory access is a list of
  // phases still to complete (1 = indirect, 0 = read, 2 = write).
  int m_cycle;
  int slot_dec, slot_exe, next_tag;
  int phases[$];
  bit wb_pend;

  function automatic bit is_taken(input logic [15:0] ir, input logic [2:0] flags);
    logic [3:0] op;
    logic [2:0] nzp;
    op  = ir[15:12];
    nzp = ir[11:9];
    return (op == 4'd0 && (nzp & flags) != 3'd0) || (op == 4'd12);
  endfunction

  function automatic bit is_alu(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    return op == 4'd1 || op == 4'd5 || op == 4'd9 || op == 4'd14;
  endfunction

  always @(negedge clock) begin
    bit busy, stall_m, fetch_m, dec_m, exe_m, br_m;
    int ph;
    logic [3:0] op;
    if (!reset) begin
      m_cycle  = 0;
      slot_dec = 0;
      slot_exe = 0;
      next_tag = 0;
      phases.delete();
      wb_pend  = 0;
      chk("m_rst_fetch", 16'(enable_fetch), 16'd0);
      chk("m_rst_upc",   16'(enable_updatePC), 16'd0);
      chk("m_rst_dec",   16'(enable_decode), 16'd0);
      chk("m_rst_exe",   16'(enable_execute), 16'd0);
      chk("m_rst_wb",    16'(enable_writeback), 16'd0);
      chk("m_rst_br",    16'(br_taken), 16'd0);
      chk("m_rst_mem",   16'(mem_state), 16'd3);
    end else begin
      busy    = phases.size() > 0;
      ph      = busy ? phases[0] : 3;
      stall_m = busy || !complete_instr;
      fetch_m = (m_cycle >= RESET_FILL) && !stall_m;
      dec_m   = (slot_dec != 0) && !stall_m;
      exe_m   = (slot_exe != 0) && !stall_m;
      br_m    = exe_m && is_taken(ir_exec, psr);
      chk("m_fetch", 16'(enable_fetch), 16'(fetch_m));
      chk("m_upc",   16'(enable_updatePC), 16'(fetch_m || br_m));
      chk("m_dec",   16'(enable_decode), 16'(dec_m));
      chk("m_exe",   16'(enable_execute), 16'(exe_m));
      chk("m_wb",    16'(enable_writeback), 16'(wb_pend));
      chk("m_br",    16'(br_taken), 16'(br_m));
      chk("m_mem",   16'(mem_state), 16'(ph));

      if (m_cycle < RESET_FILL) m_cycle++;
      wb_pend = (exe_m && is_alu(ir_exec)) || (busy && ph == 0 && complete_data);
      if (busy && complete_data) void'(phases.pop_front());
      if (exe_m) begin
        op = ir_exec[15:12];
        case (op)
          4'd2, 4'd6: phases.push_back(0);
          4'd3, 4'd7: phases.push_back(2);
          4'd10: begin phases.push_back(1); phases.push_back(0); end
          4'd11: begin phases.push_back(1); phases.push_back(2); end
          default: ;
        endcase
      end
      if (!stall_m) begin
        if (br_m) begin
          slot_dec = 0;
          slot_exe = 0;
        end else begin
          slot_exe = slot_dec;
          if (fetch_m) begin
            next_tag++;
            slot_dec = next_tag;
          end else begin
            slot_dec = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic startup_checks();
    @(negedge clock);
    chk("c0_fetch", 16'(enable_fetch), 16'd0);
    tick();
    @(negedge clock);
    chk("c1_fetch", 16'(enable_fetch), 16'd1);
    chk("c1_upc",   16'(enable_updatePC), 16'd1);
    chk("c1_dec",   16'(enable_decode), 16'd0);
    tick();
    @(negedge clock);
    chk("c2_dec", 16'(enable_decode), 16'd1);
    chk("c2_exe", 16'(enable_execute), 16'd0);
    tick();
    @(negedge clock);
    chk("c3_exe", 16'(enable_execute), 16'd1);
  endtask

  initial begin
    reset          = 1'b0;
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    ir_exec        = 16'h0000;
    psr            = 3'b000;

    @(negedge clock);
    chk("rst_mem",   16'(mem_state), 16'd3);
    chk("rst_fetch", 16'(enable_fetch), 16'd0);
    tick();
    reset = 1'b1;
    startup_checks();

    // ADD: writeback exactly one cycle after execute
    tick(); ir_exec = 16'h1021;
    @(negedge clock); chk("add_wb0", 16'(enable_writeback), 16'd0);
    tick(); ir_exec = 16'h0000;
    @(negedge clock); chk("add_wb1", 16'(enable_writeback), 16'd1);
    chk("add_nostall", 16'(enable_execute), 16'd1);
    tick();
    @(negedge clock); chk("add_wb2", 16'(enable_writeback), 16'd0);

    // BRz taken
    tick(); ir_exec = 16'h05FE; psr = 3'b010;
    @(negedge clock); chk("brz_taken", 16'(br_taken), 16'd1);
    chk("brz_upc", 16'(enable_updatePC), 16'd1);
    tick(); ir_exec = 16'h0000;
    @(negedge clock); chk("brz_n1_dec", 16'(enable_decode), 16'd0);
    chk("brz_n1_exe", 16'(enable_execute), 16'd0);
    tick();
    @(negedge clock); chk("brz_n2_exe", 16'(enable_execute), 16'd0);
    tick();
    @(negedge clock); chk("brz_n3_exe", 16'(enable_execute), 16'd1);

    // BRz not taken
    tick(); ir_exec = 16'h05FE; psr = 3'b001;
    @(negedge clock); chk("brz_nt", 16'(br_taken), 16'd0);
    tick(); ir_exec = 16'h0000;
    @(negedge clock); chk("brz_nt_dec", 16'(enable_decode), 16'd1);
    chk("brz_nt_exe", 16'(enable_execute), 16'd1);

    // LDI: indirect 3 cycles, read 2 cycles
    tick(); ir_exec = 16'hA402;
    @(negedge clock); chk("ldi_mem0", 16'(mem_state), 16'd3);
    tick(); ir_exec = 16'h0000;
    @(negedge clock); chk("ldi_mem1", 16'(mem_state), 16'd1);
    chk("ldi_fetch", 16'(enable_fetch), 16'd0);
    tick();
    @(negedge clock); chk("ldi_mem2", 16'(mem_state), 16'd1);
    tick(); complete_data = 1'b1;
    @(negedge clock); chk("ldi_mem3", 16'(mem_state), 16'd1);
    tick(); complete_data = 1'b0;
    @(negedge clock); chk("ldi_mem4", 16'(mem_state), 16'd0);
    tick(); complete_data = 1'b1;
    @(negedge clock); chk("ldi_mem5", 16'(mem_state), 16'd0);
    chk("ldi_wb5", 16'(enable_writeback), 16'd0);
    tick(); complete_data = 1'b0;
    @(negedge clock); chk("ldi_mem6", 16'(mem_state), 16'd3);
    chk("ldi_wb6", 16'(enable_writeback), 16'd1);
    chk("ldi_resume", 16'(enable_execute), 16'd1);
    tick();
    @(negedge clock); chk("ldi_wb7", 16'(enable_writeback), 16'd0);

    // STI: 1 -> 2 -> 3, no writeback
    tick(); ir_exec = 16'hB402;
    @(negedge clock);
    tick(); ir_exec = 16'h0000; complete_data = 1'b1;
    @(negedge clock); chk("sti_mem1", 16'(mem_state), 16'd1);
    tick();
    @(negedge clock); chk("sti_mem2", 16'(mem_state), 16'd2);
    tick(); complete_data = 1'b0;
    @(negedge clock); chk("sti_mem3", 16'(mem_state), 16'd3);
    chk("sti_wb", 16'(enable_writeback), 16'd0);
    tick();
    @(negedge clock); chk("sti_wb2", 16'(enable_writeback), 16'd0);

    // complete_instr low for two cycles
    for (int i = 0; i < 2; i++) begin
      tick(); complete_instr = 1'b0;
      @(negedge clock);
      chk("ci_fetch", 16'(enable_fetch), 16'd0);
      chk("ci_dec",   16'(enable_decode), 16'd0);
      chk("ci_exe",   16'(enable_execute), 16'd0);
    end
    tick(); complete_instr = 1'b1;
    @(negedge clock); chk("ci_dec_after", 16'(enable_decode), 16'd1);
    chk("ci_exe_after", 16'(enable_execute), 16'd1);

    // Asynchronous reset during a read
    tick(); ir_exec = 16'h2402;
    @(negedge clock);
    tick(); ir_exec = 16'h0000;
    @(negedge clock); chk("ld_mem", 16'(mem_state), 16'd0);
    @(posedge clock); #3;
    reset = 1'b0;
    complete_data = 1'b1;
    #1;
    chk("arst_mem",   16'(mem_state), 16'd3);
    chk("arst_fetch", 16'(enable_fetch), 16'd0);
    chk("arst_upc",   16'(enable_updatePC), 16'd0);
    chk("arst_dec",   16'(enable_decode), 16'd0);
    chk("arst_exe",   16'(enable_execute), 16'd0);
    chk("arst_wb",    16'(enable_writeback), 16'd0);
    tick();
    reset = 1'b1;
    startup_checks();
    complete_data = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
